// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: one-hot opcode in, single registered result out.
// Define ALU_SEQ_DIV_EN to build in the 32-step restoring divider for div/mod.
module alu_sequencer #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [12:0] alu_signals,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] result,
   output logic [1:0]  flags,
   output logic        err,
   output logic        stall,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both
   // high; valid never waits on ready, and result/err hold while res_valid & ~res_ready.

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL_WAIT = 2'd1, DIV_RUN = 2'd2, DONE = 2'd3} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL_WAIT = 2'd1, DONE = 2'd3} state_e;
`endif

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic [1:0]  flags_q, flags_d;
   logic        err_q, err_d;
   logic        res_valid_q, res_valid_d;
   logic        op_ready_q, op_ready_d;
   logic [12:0] sel;
   logic        shamt_big;
`ifdef ALU_SEQ_DIV_EN
   logic [31:0] rem_q, rem_d;
   logic        is_mod_q, is_mod_d;
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        q_bit;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      flags_d     = flags_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      op_ready_d  = op_ready_q;
      // isolate the lowest set opcode bit so multi-hot inputs pick one op
      sel         = alu_signals & (~alu_signals + 13'd1);
      shamt_big   = |operand_b[31:5];
`ifdef ALU_SEQ_DIV_EN
      rem_d       = rem_q;
      is_mod_d    = is_mod_q;
      rem_sh      = {rem_q, a_q[31]};
      diff        = rem_sh - {1'b0, b_q};
      q_bit       = ~diff[32];
`endif
      case (state_q)
         IDLE: begin
            if (op_valid && op_ready_q) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
               op_ready_d  = 1'b0;
               res_d       = '0;
               err_d       = 1'b0;
               case (sel)
                  13'h0001: res_d = operand_a + operand_b;
                  13'h0002: res_d = operand_a - operand_b;
                  13'h0004: begin
                     res_d   = operand_a - operand_b;
                     flags_d = {$signed(operand_a) > $signed(operand_b), operand_a == operand_b};
                  end
                  13'h0008: begin
                     a_d = operand_a;
                     b_d = operand_b;
                     if (MUL_LAT <= 1) begin
                        res_d = operand_a * operand_b;
                     end else begin
                        state_d     = MUL_WAIT;
                        res_valid_d = 1'b0;
                        cnt_d       = 5'(MUL_LAT - 2);
                     end
                  end
                  13'h0010, 13'h0020: begin
`ifdef ALU_SEQ_DIV_EN
                     is_mod_d = sel[5];
                     if (operand_b == 32'd0) begin
                        res_d = sel[5] ? operand_a : 32'hFFFF_FFFF;
                        err_d = 1'b1;
                     end else begin
                        // a_q doubles as the dividend/quotient shift register
                        a_d         = operand_a;
                        b_d         = operand_b;
                        rem_d       = '0;
                        cnt_d       = '0;
                        state_d     = DIV_RUN;
                        res_valid_d = 1'b0;
                     end
`else
                     err_d = 1'b1;
`endif
                  end
                  13'h0040: res_d = shamt_big ? 32'd0 : operand_a << operand_b[4:0];
                  13'h0080: res_d = shamt_big ? 32'd0 : operand_a >> operand_b[4:0];
                  13'h0100: res_d = shamt_big ? {32{operand_a[31]}}
                                              : $unsigned($signed(operand_a) >>> operand_b[4:0]);
                  13'h0200: res_d = operand_a | operand_b;
                  13'h0400: res_d = operand_a & operand_b;
                  13'h0800: res_d = ~operand_a;
                  13'h1000: res_d = operand_b;
                  default:  res_d = '0;
               endcase
            end
         end
         MUL_WAIT: begin
            if (cnt_q == 5'd0) begin
               res_d       = a_q * b_q;
               state_d     = DONE;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         DIV_RUN: begin
            rem_d = q_bit ? diff[31:0] : rem_sh[31:0];
            a_d   = {a_q[30:0], q_bit};
            if (cnt_q == 5'd31) begin
               res_d       = is_mod_q ? rem_d : a_d;
               state_d     = DONE;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
`endif
         DONE: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               op_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            op_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         op_ready_q  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
         rem_q       <= '0;
         is_mod_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         op_ready_q  <= op_ready_d;
`ifdef ALU_SEQ_DIV_EN
         rem_q       <= rem_d;
         is_mod_q    <= is_mod_d;
`endif
      end
   end

   assign op_ready  = op_ready_q;
   assign res_valid = res_valid_q;
   assign result    = res_q;
   assign flags     = flags_q;
   assign err       = err_q;
   assign stall     = op_valid & ~op_ready_q;
   assign dbg_state = state_q;

endmodule
